// File: rtl/dac_out_if.sv
// rtl/dac_out_if.sv - upstream word stream into the DAC playback block
interface dac_out_if #(
  parameter int SAMPLE_W = 12
);
  logic [2*SAMPLE_W-1:0] dac_data_double;
  logic                  dac_valid;
  logic                  dac_ready;

  modport master (
    output dac_data_double,
    output dac_valid,
    input  dac_ready
  );

  modport slave (
    input  dac_data_double,
    input  dac_valid,
    output dac_ready
  );
endinterface

// File: rtl/dac_out.sv
// rtl/dac_out.sv - FIFO-buffered double-sample playback to a parallel DAC (option: DAC_UNDERRUN_CNT_EN)
module dac_out #(
  parameter int                  SAMPLE_W   = 12,
  parameter int                  FIFO_DEPTH = 4,
  parameter logic [SAMPLE_W-1:0] MIDSCALE   = 12'h800
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dac_enable,
  input  logic [7:0]          dac_clock_div,
  dac_out_if.slave            up,
  output logic [SAMPLE_W-1:0] dac_pins,
  output logic                dac_clock_pin,
`ifdef DAC_UNDERRUN_CNT_EN
  output logic [15:0]         dac_underrun_cnt,
`endif
  output logic                dac_underrun
);

  localparam int WORD_W = 2 * SAMPLE_W;
  localparam int PW     = $clog2(FIFO_DEPTH);
  localparam int CW     = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  typedef enum logic {PH_A, PH_B} phase_t;

  logic [WORD_W-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr;
  logic [PW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [7:0]          div_cnt;
  logic [SAMPLE_W-1:0] hold;
  phase_t              phase;

  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              div_term;
  logic              fall_tick;
  logic              underrun_tick;
  logic [WORD_W-1:0] head_word;

  // Ready comes only from the registered count, so a pop never reopens it in the same cycle.
  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign up.dac_ready = !full;
  assign push      = up.dac_valid && !full;
  assign head_word = mem[rd_ptr];

  // >= rather than == so a divider lowered below the running count still terminates next compare.
  assign div_term      = (div_cnt >= dac_clock_div);
  assign fall_tick     = dac_enable && div_term && dac_clock_pin;
  assign pop           = fall_tick && (phase == PH_A) && !empty;
  assign underrun_tick = fall_tick && (phase == PH_A) && empty;

  // Word storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= up.dac_data_double;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Conversion clock divider: toggle the DAC clock at each terminal count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      dac_clock_pin <= 1'b0;
    end else if (!dac_enable) begin
      div_cnt       <= '0;
      dac_clock_pin <= 1'b0;
    end else if (div_term) begin
      div_cnt       <= '0;
      dac_clock_pin <= ~dac_clock_pin;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Sample sequencer: on each falling DAC clock, play upper half, then the held lower half.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_pins     <= MIDSCALE;
      hold         <= '0;
      phase        <= PH_A;
      dac_underrun <= 1'b0;
    end else if (!dac_enable) begin
      phase        <= PH_A;
      dac_underrun <= 1'b0;
    end else if (fall_tick) begin
      case (phase)
        PH_A: begin
          if (!empty) begin
            dac_pins <= head_word[WORD_W-1:SAMPLE_W];
            hold     <= head_word[SAMPLE_W-1:0];
            phase    <= PH_B;
          end else begin
            dac_pins     <= MIDSCALE;
            dac_underrun <= 1'b1;
          end
        end
        PH_B: begin
          dac_pins <= hold;
          phase    <= PH_A;
        end
      endcase
    end
  end

`ifdef DAC_UNDERRUN_CNT_EN
  // Saturating count of underrun ticks since reset or the last enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_underrun_cnt <= '0;
    end else if (!dac_enable) begin
      dac_underrun_cnt <= '0;
    end else if (underrun_tick && (dac_underrun_cnt != 16'hFFFF)) begin
      dac_underrun_cnt <= dac_underrun_cnt + 1'b1;
    end
  end
`else
  logic unused_underrun_tick;
  assign unused_underrun_tick = underrun_tick;
`endif

endmodule

// File: tb/tb_dac_out.sv
// tb/tb_dac_out.sv - scoreboard bench for dac_out
module tb_dac_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dac_enable = 1'b0;
  logic [7:0]  div = 8'd2;
  logic [11:0] pins;
  logic        cpin;
  logic        urun;
`ifdef DAC_UNDERRUN_CNT_EN
  logic [15:0] ucnt;
`endif

  dac_out_if #(.SAMPLE_W(12)) bus ();

  dac_out dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .dac_enable       (dac_enable),
    .dac_clock_div    (div),
    .up               (bus),
    .dac_pins         (pins),
    .dac_clock_pin    (cpin),
`ifdef DAC_UNDERRUN_CNT_EN
    .dac_underrun_cnt (ucnt),
`endif
    .dac_underrun     (urun)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int n_ticks    = 0;
  int tick_cyc   = 0;
  int en_cyc     = 0;
  logic [11:0] exp_q[$];

  always @(posedge clk) cyc++;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Monitor: a falling DAC clock while enabled is a sample presentation.
  logic last_pin = 1'b0;
  logic last_en  = 1'b0;
  int   since_tick = 0;
  bit   rise_armed = 0;
  bit   tick_armed = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      last_pin   = 1'b0;
      last_en    = 1'b0;
      rise_armed = 0;
      tick_armed = 0;
    end else begin
      if (!last_en) begin
        rise_armed = 0;
        tick_armed = 0;
      end
      since_tick++;
      if (last_pin && !cpin && last_en) begin
        n_ticks++;
        tick_cyc = cyc;
        if (tick_armed) check("tick_spacing", since_tick, 2 * (div + 1));
        if (exp_q.size() > 0) begin
          check("pins", {20'd0, pins}, {20'd0, exp_q.pop_front()});
        end else begin
          check("underrun_pins", {20'd0, pins}, 32'h800);
          check("underrun_flag", {31'd0, urun}, 32'd1);
        end
        since_tick = 0;
        rise_armed = 1;
        tick_armed = 1;
      end else if (!last_pin && cpin && rise_armed) begin
        check("rise_delay", since_tick, div + 1);
        rise_armed = 0;
      end
      last_pin = cpin;
      last_en  = dac_enable;
    end
  end

  task automatic wait_ticks(input int n, input int budget);
    int base = n_ticks;
    for (int k = 0; k < budget && n_ticks < base + n; k++) begin
      @(posedge clk); #2;
    end
    check("ticks_seen", n_ticks - base, n);
  endtask

  task automatic wait_drain(input int budget);
    for (int k = 0; k < budget && exp_q.size() > 0; k++) begin
      @(posedge clk); #2;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic push(input logic [23:0] w, input int budget);
    bit ok = 0;
    bus.dac_data_double = w;
    bus.dac_valid = 1'b1;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (bus.dac_ready) ok = 1;
    end
    @(posedge clk); #2;
    bus.dac_valid = 1'b0;
    check("push_accept", {31'd0, ok}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] words [5];
    words[0] = 24'h111222; words[1] = 24'h333444; words[2] = 24'h555666;
    words[3] = 24'h777888; words[4] = 24'h999AAA;
    bus.dac_valid = 1'b0;
    bus.dac_data_double = '0;

    // Reset state
    repeat (3) @(posedge clk); #2;
    check("rst_pins", {20'd0, pins}, 32'h800);
    check("rst_clock_pin", {31'd0, cpin}, 32'd0);
    check("rst_ready", {31'd0, bus.dac_ready}, 32'd1);
    check("rst_underrun", {31'd0, urun}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Single word, div = 2
    div = 8'd2;
    push(24'hABC123, 20);
    exp_q.push_back(12'hABC);
    exp_q.push_back(12'h123);
    dac_enable = 1'b1;
    en_cyc = cyc;
    wait_ticks(1, 50);
    check("first_tick_latency", tick_cyc - en_cyc, 6);
    wait_drain(50);
    check("no_underrun_yet", {31'd0, urun}, 32'd0);
    dac_enable = 1'b0;
    @(posedge clk); #2;

    // Fill FIFO while disabled, then hold a fifth word
    div = 8'd0;
    for (int i = 0; i < 4; i++) begin
      push(words[i], 20);
      check("ready_after_push", {31'd0, bus.dac_ready}, (i < 3) ? 32'd1 : 32'd0);
    end
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(words[i][23:12]);
      exp_q.push_back(words[i][11:0]);
    end
    bus.dac_data_double = words[4];
    bus.dac_valid = 1'b1;
    repeat (3) @(posedge clk); #2;
    check("held_not_accepted", {31'd0, bus.dac_ready}, 32'd0);
    dac_enable = 1'b1;
    push(words[4], 50);
    wait_drain(200);
    wait_ticks(2, 50);
    dac_enable = 1'b0;
    repeat (2) @(posedge clk); #2;

    // Underrun from an empty FIFO, div = 0
    check("underrun_cleared", {31'd0, urun}, 32'd0);
    dac_enable = 1'b1;
    wait_ticks(3, 50);
    check("underrun_set", {31'd0, urun}, 32'd1);
`ifdef DAC_UNDERRUN_CNT_EN
    check("underrun_cnt", {16'd0, ucnt}, 32'd3);
`endif
    dac_enable = 1'b0;
    repeat (2) @(posedge clk); #2;

    // Drop enable in PH_B
    div = 8'd2;
    push(24'hABC123, 20);
    push(24'hDEF456, 20);
    exp_q.push_back(12'hABC);
    dac_enable = 1'b1;
    wait_ticks(1, 50);
    dac_enable = 1'b0;
    repeat (4) @(posedge clk); #2;
    check("hold_pins", {20'd0, pins}, 32'hABC);
    check("hold_clock_pin", {31'd0, cpin}, 32'd0);
    exp_q.push_back(12'hDEF);
    exp_q.push_back(12'h456);
    dac_enable = 1'b1;
    wait_drain(100);
    wait_ticks(1, 50);
    dac_enable = 1'b0;
    repeat (2) @(posedge clk); #2;

    // Asynchronous reset mid-stream
    div = 8'd1;
    push(24'h13579B, 20);
    push(24'h2468AC, 20);
    exp_q.push_back(12'h135);
    dac_enable = 1'b1;
    wait_ticks(1, 50);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_pins", {20'd0, pins}, 32'h800);
    check("arst_clock_pin", {31'd0, cpin}, 32'd0);
    check("arst_ready", {31'd0, bus.dac_ready}, 32'd1);
    check("arst_underrun", {31'd0, urun}, 32'd0);
    exp_q.delete();
    dac_enable = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;
    dac_enable = 1'b1;
    wait_ticks(1, 50);
    dac_enable = 1'b0;
    repeat (2) @(posedge clk); #2;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
